data_path: RTL and testbench
============================

DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 SHALL have port clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have register-load strobes, input, 1 bit each: PCin, IRin, Yin, MDRin, MARin, Zlowin, Zhighin, Rin.
REQ-004 SHALL have bus-drive strobes, input, 1 bit each: PCout, MDRout, Zlowout, Rout, BAout, Csignout.
REQ-005 SHALL have register-select controls, input, 1 bit each: Gra (select IR.ra) and Grb (select IR.rb).
REQ-006 SHALL have ALU operation controls, input, 1 bit each: AND, IncPC.
REQ-007 SHALL have memory controls, input, 1 bit each: Read, Write, MD_read (MDR source is memory, not bus), MAR_clear.
REQ-008 SHALL have observation outputs: BusMuxOut (32 bits, the bus value), PCq (32), IRq (32), MARq (32).

Function
REQ-009 SHALL hold state: R0-R15, PC, IR, Y, MAR and MDR, each 32 bits; Z, 64 bits, split into Zlow and Zhigh; Mdatain, 32 bits; and RAM of 512x32.
REQ-010 SHALL drive the bus combinationally, by priority: PCout > Zlowout > MDRout > Rout/BAout > Csignout; with no drive strobe asserted, bus = 0.
REQ-011 SHALL use this IR field layout: opcode [31:27], ra [26:23], rb [22:19], C [18:0].
REQ-012 SHALL form the register index as ra when Gra is asserted, rb when Grb is asserted, with Gra winning if both are asserted; with neither asserted, Rin and Rout/BAout have no effect.
REQ-013 SHALL drive the bus with R[index] on Rout; on BAout it SHALL drive R[index], except that index 0 drives 0.
REQ-014 SHALL write the bus into R[index] on Rin, including R0.
REQ-015 SHALL drive the bus on Csignout with C sign-extended from bit 18 to 32 bits.
REQ-016 SHALL compute the ALU result combinationally (64 bits) from operand A = Y and operand B = bus:
- IncPC: result = bus + 1;
- else AND: result = Y & bus;
- else: result = Y + bus, with the carry in bit 32.
- Upper bits of the result are 0 except the ADD carry.
REQ-017 SHALL load Zlow with result[31:0] on Zlowin, and Zhigh with result[63:32] on Zhighin, independently.
REQ-018 SHALL load PC, IR, Y and MAR from the bus on their respective in-strobes.
REQ-019 SHALL clear MAR to 0 on MAR_clear, with priority over MARin.
REQ-020 SHALL register Mdatain <= RAM[MAR[8:0]] on Read, so the data is valid the cycle after Read.
REQ-021 SHALL load MDR on MDRin: from Mdatain if MD_read is asserted, else from the bus.
REQ-022 SHALL perform RAM[MAR[8:0]] <= MDR on Write; on Read and Write in the same cycle, Mdatain gets the old contents.
REQ-023 SHALL resolve same-cycle out and in strobes as read-before-write: a register may drive the bus and load in one cycle; a register load takes the pre-edge bus value.
REQ-024 SHALL ignore MAR bits 31:9 for addressing, so addresses wrap modulo 512.

Reset
REQ-025 SHALL, on clear asserted at a rising edge, zero R0-R15, PC, IR, Y, Z, MAR, MDR and Mdatain; clear has priority over all strobes.
REQ-026 SHALL leave RAM contents unaffected by clear; the bench preloads RAM via $readmemh in simulation.
REQ-027 SHALL have BusMuxOut equal 0 while in reset with no drive strobe asserted.

Structure
REQ-028 SHALL place in a shared package: the IR field bit positions, RAM depth (512), data width (32) and register count (16).
REQ-029 SHALL use one sub-module, data_path_ram (512x32, synchronous read and write); the ALU and select/encode logic stay inline.

Verification
REQ-030 SHALL check fetch: RAM[0]=0x5220000F, reset; cycle 1 PCout+MARin+IncPC+Zlowin; cycle 2 Zlowout+PCin+Read; cycle 3 MD_read+MDRin; cycle 4 MDRout+IRin -> PCq=1, MARq=0, IRq=0x5220000F.
REQ-031 SHALL check ANDI after that fetch:
- MDRout+Gra+Rin -> R4=0x5220000F;
- Grb+Rout+Yin, then Csignout+AND+Zlowin, then Zlowout+Gra+Rin -> R4=0x0000000F.
REQ-032 SHALL check sign extension: IR=0x5227FFFF with Csignout -> BusMuxOut=0xFFFFFFFF; IR C=0x3FFFF -> 0x0003FFFF.
REQ-033 SHALL check BAout: R0 loaded with 0xDEADBEEF, IR rb=0, Grb+BAout -> bus 0; Grb+Rout -> 0xDEADBEEF.
REQ-034 SHALL check ADD and memory: Y=0xFFFFFFFF, bus=1, Zlowin+Zhighin -> Zlow=0, Zhigh=1; MDR=0xA5A5A5A5, MAR=0x205, Write then Read -> Mdatain=0xA5A5A5A5 (RAM[5]).
REQ-035 SHALL check reset mid-operation: clear asserted during the Zlowin cycle -> Z=0, PCq=0, MARq=0.

Source files
------------

// File: rtl/data_path_pkg.sv
// Shared definitions for the data_path block.
// Holds the datapath width, register-file size, RAM geometry, IR field
// positions, the bus-source encoding, and the C-field sign extension.
package data_path_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_N      = 16;
  localparam int REG_IDX_W  = 4;
  localparam int RAM_DEPTH  = 512;
  localparam int RAM_ADDR_W = 9;

  // IR layout: opcode | ra | rb | C
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int C_MSB   = 18;
  localparam int C_LSB   = 0;

  // Which source currently owns the bus. SRC_ZERO is the BAout-on-R0 case.
  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_PC,
    SRC_ZLOW,
    SRC_MDR,
    SRC_REG,
    SRC_ZERO,
    SRC_CSIGN
  } bus_src_e;

  // Sign-extend the IR immediate field to a full data word.
  function automatic logic [DATA_W-1:0] sext_c(input logic [C_MSB:C_LSB] c);
    return {{(DATA_W-C_MSB-1){c[C_MSB]}}, c};
  endfunction

endpackage

// File: rtl/data_path_ram.sv
// 512x32 single-port RAM with synchronous read and write.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset; clears the read register only
//             and blocks writes, memory contents are kept
//   rd_en   - capture mem[addr] into rdata_q at the next edge
//   wr_en   - write wdata into mem[addr] at the next edge
//   addr    - word address
//   wdata   - write data
//   rdata_q - registered read data (old contents on read+write same cycle)
module data_path_ram
  import data_path_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [RAM_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata_q
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[addr] <= wdata;
  end

endmodule

// File: rtl/data_path.sv
// Single-bus CPU datapath: 16-entry register file, PC, IR, Y, Z (64-bit,
// split low/high), MAR, MDR and a 512x32 RAM, with a priority bus mux and
// a small ALU (increment, AND, add with carry-out).
// Ports:
//   clock, clear          - clock and synchronous active-high reset
//   PCin..Rin             - register load strobes (take the pre-edge bus)
//   PCout..Csignout       - bus drive strobes, priority PC > Zlow > MDR >
//                           R/BA > Csign; bus is 0 when nothing drives
//   Gra, Grb              - choose IR.ra / IR.rb as register index
//   AND, IncPC            - ALU operation select (default is add)
//   Read, Write           - RAM access at MAR[8:0]
//   MD_read               - MDR loads from memory data instead of the bus
//   MAR_clear             - zero MAR, wins over MARin
//   BusMuxOut, PCq, IRq, MARq - observation outputs
module data_path
  import data_path_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        MDRin,
  input  logic        MARin,
  input  logic        Zlowin,
  input  logic        Zhighin,
  input  logic        Rin,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        Zlowout,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        Csignout,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        AND,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        Write,
  input  logic        MD_read,
  input  logic        MAR_clear,
  output logic [31:0] BusMuxOut,
  output logic [31:0] PCq,
  output logic [31:0] IRq,
  output logic [31:0] MARq
);

  logic [DATA_W-1:0] r_q [REG_N];
  logic [DATA_W-1:0] r_d [REG_N];
  logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d, y_q, y_d;
  logic [DATA_W-1:0] mar_q, mar_d, mdr_q, mdr_d;
  logic [DATA_W-1:0] zlow_q, zlow_d, zhigh_q, zhigh_d;
  logic [DATA_W-1:0] mdatain;

  logic [REG_IDX_W-1:0] reg_idx;
  logic                 reg_sel;
  bus_src_e             bus_src;
  logic [DATA_W-1:0]    bus;
  logic [DATA_W:0]      add_sum;
  logic [2*DATA_W-1:0]  alu_res;

  // Register index: Gra wins over Grb; with neither, the register file is
  // neither read onto the bus nor written.
  always_comb begin
    reg_idx = Grb ? ir_q[RB_MSB:RB_LSB] : '0;
    if (Gra) reg_idx = ir_q[RA_MSB:RA_LSB];
    reg_sel = Gra | Grb;
  end

  always_comb begin
    bus_src = SRC_NONE;
    if (PCout)                          bus_src = SRC_PC;
    else if (Zlowout)                   bus_src = SRC_ZLOW;
    else if (MDRout)                    bus_src = SRC_MDR;
    else if (reg_sel && (Rout || BAout))
      // BAout reads R0 as constant zero (base-address addressing).
      bus_src = (BAout && reg_idx == '0) ? SRC_ZERO : SRC_REG;
    else if (Csignout)                  bus_src = SRC_CSIGN;
  end

  always_comb begin
    case (bus_src)
      SRC_PC:    bus = pc_q;
      SRC_ZLOW:  bus = zlow_q;
      SRC_MDR:   bus = mdr_q;
      SRC_REG:   bus = r_q[reg_idx];
      SRC_CSIGN: bus = sext_c(ir_q[C_MSB:C_LSB]);
      default:   bus = '0;
    endcase
  end

  // ALU: A = Y, B = bus. Only the add can set anything in the upper half.
  always_comb begin
    add_sum = {1'b0, y_q} + {1'b0, bus};
    if (IncPC)    alu_res = {{DATA_W{1'b0}}, bus + DATA_W'(1)};
    else if (AND) alu_res = {{DATA_W{1'b0}}, y_q & bus};
    else          alu_res = {{(DATA_W-1){1'b0}}, add_sum};
  end

  always_comb begin
    for (int i = 0; i < REG_N; i++) r_d[i] = r_q[i];
    if (Rin && reg_sel) r_d[reg_idx] = bus;

    pc_d    = PCin    ? bus : pc_q;
    ir_d    = IRin    ? bus : ir_q;
    y_d     = Yin     ? bus : y_q;
    zlow_d  = Zlowin  ? alu_res[DATA_W-1:0]        : zlow_q;
    zhigh_d = Zhighin ? alu_res[2*DATA_W-1:DATA_W] : zhigh_q;

    mar_d = mar_q;
    if (MAR_clear)  mar_d = '0;
    else if (MARin) mar_d = bus;

    mdr_d = mdr_q;
    if (MDRin) mdr_d = MD_read ? mdatain : bus;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < REG_N; i++) r_q[i] <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      y_q     <= '0;
      zlow_q  <= '0;
      zhigh_q <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      for (int i = 0; i < REG_N; i++) r_q[i] <= r_d[i];
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      y_q     <= y_d;
      zlow_q  <= zlow_d;
      zhigh_q <= zhigh_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  // Upper MAR bits are ignored, so addresses wrap modulo the RAM depth.
  data_path_ram u_ram (
    .clk     (clock),
    .rst     (clear),
    .rd_en   (Read),
    .wr_en   (Write),
    .addr    (mar_q[RAM_ADDR_W-1:0]),
    .wdata   (mdr_q),
    .rdata_q (mdatain)
  );

  assign BusMuxOut = bus;
  assign PCq       = pc_q;
  assign IRq       = ir_q;
  assign MARq      = mar_q;

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;

  logic        clock = 1'b0;
  logic        clear;
  logic [21:0] ctl;
  logic [31:0] BusMuxOut, PCq, IRq, MARq;

  always #5 clock = ~clock;

  localparam logic [21:0] PCIN     = 22'h1 << 0;
  localparam logic [21:0] IRIN     = 22'h1 << 1;
  localparam logic [21:0] YIN      = 22'h1 << 2;
  localparam logic [21:0] MDRIN    = 22'h1 << 3;
  localparam logic [21:0] MARIN    = 22'h1 << 4;
  localparam logic [21:0] ZLOWIN   = 22'h1 << 5;
  localparam logic [21:0] ZHIGHIN  = 22'h1 << 6;
  localparam logic [21:0] RIN      = 22'h1 << 7;
  localparam logic [21:0] PCOUT    = 22'h1 << 8;
  localparam logic [21:0] MDROUT   = 22'h1 << 9;
  localparam logic [21:0] ZLOWOUT  = 22'h1 << 10;
  localparam logic [21:0] ROUT     = 22'h1 << 11;
  localparam logic [21:0] BAOUT    = 22'h1 << 12;
  localparam logic [21:0] CSIGNOUT = 22'h1 << 13;
  localparam logic [21:0] GRA      = 22'h1 << 14;
  localparam logic [21:0] GRB      = 22'h1 << 15;
  localparam logic [21:0] ANDOP    = 22'h1 << 16;
  localparam logic [21:0] INCPC    = 22'h1 << 17;
  localparam logic [21:0] READ     = 22'h1 << 18;
  localparam logic [21:0] WRITE    = 22'h1 << 19;
  localparam logic [21:0] MDREAD   = 22'h1 << 20;
  localparam logic [21:0] MARCLR   = 22'h1 << 21;

  data_path dut (
    .clock     (clock),
    .clear     (clear),
    .PCin      (ctl[0]),
    .IRin      (ctl[1]),
    .Yin       (ctl[2]),
    .MDRin     (ctl[3]),
    .MARin     (ctl[4]),
    .Zlowin    (ctl[5]),
    .Zhighin   (ctl[6]),
    .Rin       (ctl[7]),
    .PCout     (ctl[8]),
    .MDRout    (ctl[9]),
    .Zlowout   (ctl[10]),
    .Rout      (ctl[11]),
    .BAout     (ctl[12]),
    .Csignout  (ctl[13]),
    .Gra       (ctl[14]),
    .Grb       (ctl[15]),
    .AND       (ctl[16]),
    .IncPC     (ctl[17]),
    .Read      (ctl[18]),
    .Write     (ctl[19]),
    .MD_read   (ctl[20]),
    .MAR_clear (ctl[21]),
    .BusMuxOut (BusMuxOut),
    .PCq       (PCq),
    .IRq       (IRq),
    .MARq      (MARq)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of the architectural state.
  logic [31:0] mr [16];
  logic [31:0] mpc, mir, my, mmar, mmdr, mmd, mzl, mzh;
  logic [31:0] mram [512];

  function automatic logic [31:0] m_bus(input logic [21:0] m);
    int idx;
    logic sel;
    idx = m[14] ? int'(mir[26:23]) : int'(mir[22:19]);
    sel = m[14] | m[15];
    if (m[8])                          return mpc;
    if (m[10])                         return mzl;
    if (m[9])                          return mmdr;
    if (sel && (m[11] || m[12]))       return (m[12] && idx == 0) ? 32'h0 : mr[idx];
    if (m[13])                         return {{13{mir[18]}}, mir[18:0]};
    return 32'h0;
  endfunction

  task automatic m_edge(input logic [21:0] m, input logic clr);
    logic [31:0] b, nmd;
    logic [63:0] res;
    int idx;
    b   = m_bus(m);
    idx = m[14] ? int'(mir[26:23]) : int'(mir[22:19]);
    if (clr) begin
      for (int i = 0; i < 16; i++) mr[i] = 0;
      mpc = 0; mir = 0; my = 0; mmar = 0; mmdr = 0; mmd = 0; mzl = 0; mzh = 0;
      return;
    end
    if (m[17])      res = {32'h0, b + 32'h1};
    else if (m[16]) res = {32'h0, my & b};
    else            res = {32'h0, my} + {32'h0, b};
    nmd = m[18] ? mram[mmar[8:0]] : mmd;
    if (m[19]) mram[mmar[8:0]] = mmdr;
    if (m[3]) mmdr = m[20] ? mmd : b;
    mmd = nmd;
    if (m[7] && (m[14] || m[15])) mr[idx] = b;
    if (m[0]) mpc = b;
    if (m[1]) mir = b;
    if (m[2]) my = b;
    if (m[21])     mmar = 0;
    else if (m[4]) mmar = b;
    if (m[5]) mzl = res[31:0];
    if (m[6]) mzh = res[63:32];
  endtask

  // One clock cycle: drive strobes, sample the bus mid-cycle, advance.
  task automatic step(input logic [21:0] m, input logic clr,
                      output logic [31:0] obs, output logic [31:0] exp);
    exp   = m_bus(m);
    ctl   = m;
    clear = clr;
    #2;
    obs = BusMuxOut;
    @(posedge clock);
    m_edge(m, clr);
    #1;
    ctl   = '0;
    clear = 1'b0;
  endtask

  task automatic go(input logic [21:0] m);
    logic [31:0] o, e;
    step(m, 1'b0, o, e);
  endtask

  // Build an arbitrary constant in R0 through the ports only: zero IR so
  // that rb selects R0, then shift-and-add the value in MSB first.
  task automatic load_r0(input logic [31:0] v);
    logic started;
    started = 1'b0;
    go(IRIN);
    go(GRB | RIN);
    for (int i = 31; i >= 0; i--) begin
      if (started) begin
        go(GRB | ROUT | YIN);
        go(GRB | ROUT | ZLOWIN);
        go(ZLOWOUT | GRB | RIN);
      end
      if (v[i]) begin
        go(GRB | ROUT | INCPC | ZLOWIN);
        go(ZLOWOUT | GRB | RIN);
        started = 1'b1;
      end
    end
  endtask

  task automatic write_ram(input logic [31:0] a, input logic [31:0] v);
    load_r0(a);
    go(GRB | ROUT | MARIN);
    load_r0(v);
    go(GRB | ROUT | MDRIN);
    go(WRITE);
  endtask

  task automatic test_reset;
    logic [31:0] o, e;
    step('0, 1'b1, o, e);
    checks++;
    if (o !== 32'h0) begin errors++; $display("FAIL reset_bus got %h want %h", o, 32'h0); end
    load_r0(32'h0000_0123);
    go(GRB | ROUT | PCIN);
    go(GRB | ROUT | MARIN);
    go(GRB | ROUT | MDRIN);
    go(GRB | ROUT | IRIN);
    step('0, 1'b1, o, e);
    checks++;
    if ({PCq, IRq, MARq} !== 96'h0)
      begin errors++; $display("FAIL reset_regs got %h %h %h want 0 0 0", PCq, IRq, MARq); end
    step(MDROUT, 1'b0, o, e);
    checks++;
    if (o !== 32'h0) begin errors++; $display("FAIL reset_mdr got %h want %h", o, 32'h0); end
    step(GRB | ROUT, 1'b0, o, e);
    checks++;
    if (o !== 32'h0) begin errors++; $display("FAIL reset_r0 got %h want %h", o, 32'h0); end
  endtask

  task automatic test_fetch;
    logic [31:0] o, e;
    write_ram(32'h0, 32'h5220_000F);
    step('0, 1'b1, o, e);
    go(PCOUT | MARIN | INCPC | ZLOWIN);
    step(ZLOWOUT | PCIN | READ, 1'b0, o, e);
    checks++;
    if (o !== 32'h1) begin errors++; $display("FAIL fetch_zlow_bus got %h want %h", o, 32'h1); end
    go(MDREAD | MDRIN);
    go(MDROUT | IRIN);
    checks++;
    if ({PCq, MARq, IRq} !== {32'h1, 32'h0, 32'h5220_000F})
      begin errors++; $display("FAIL fetch got %h %h %h want 1 0 5220000f", PCq, MARq, IRq); end
  endtask

  task automatic test_andi;
    logic [31:0] o, e;
    go(MDROUT | GRA | RIN);
    step(GRB | ROUT, 1'b0, o, e);
    checks++;
    if (o !== 32'h5220_000F) begin errors++; $display("FAIL andi_r4_load got %h want %h", o, 32'h5220_000F); end
    go(GRB | ROUT | YIN);
    step(CSIGNOUT | ANDOP | ZLOWIN, 1'b0, o, e);
    checks++;
    if (o !== 32'h0000_000F) begin errors++; $display("FAIL andi_imm got %h want %h", o, 32'hF); end
    go(ZLOWOUT | GRA | RIN);
    step(GRB | ROUT, 1'b0, o, e);
    checks++;
    if (o !== 32'h0000_000F) begin errors++; $display("FAIL andi_result got %h want %h", o, 32'hF); end
  endtask

  task automatic test_sign_ext;
    logic [31:0] o, e;
    logic [31:0] irv  [2];
    logic [31:0] want [2];
    irv[0] = 32'h5227_FFFF; want[0] = 32'hFFFF_FFFF;
    irv[1] = 32'h5223_FFFF; want[1] = 32'h0003_FFFF;
    for (int i = 0; i < 2; i++) begin
      load_r0(irv[i]);
      go(GRB | ROUT | IRIN);
      step(CSIGNOUT, 1'b0, o, e);
      checks++;
      if (o !== want[i]) begin errors++; $display("FAIL sext_%0d got %h want %h", i, o, want[i]); end
    end
  endtask

  task automatic test_baout;
    logic [31:0] o, e;
    load_r0(32'hDEAD_BEEF);
    step(GRB | BAOUT, 1'b0, o, e);
    checks++;
    if (o !== 32'h0) begin errors++; $display("FAIL baout_r0 got %h want %h", o, 32'h0); end
    step(GRB | ROUT, 1'b0, o, e);
    checks++;
    if (o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rout_r0 got %h want %h", o, 32'hDEAD_BEEF); end
  endtask

  task automatic test_add_carry;
    logic [31:0] o, e;
    load_r0(32'h1);
    go(GRB | ROUT | PCIN);
    load_r0(32'hFFFF_FFFF);
    go(GRB | ROUT | YIN);
    go(PCOUT | ZLOWIN | ZHIGHIN);
    step(ZLOWOUT, 1'b0, o, e);
    checks++;
    if (o !== 32'h0) begin errors++; $display("FAIL add_zlow got %h want %h", o, 32'h0); end
    checks++;
    if (dut.zhigh_q !== 32'h1) begin errors++; $display("FAIL add_zhigh got %h want %h", dut.zhigh_q, 32'h1); end
  endtask

  task automatic test_memory;
    logic [31:0] o, e;
    write_ram(32'h205, 32'hA5A5_A5A5);
    load_r0(32'h5);
    go(GRB | ROUT | MARIN);
    go(MDRIN);
    go(READ);
    checks++;
    if (dut.mdatain !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mem_wrap got %h want %h", dut.mdatain, 32'hA5A5_A5A5); end
    go(MDREAD | MDRIN);
    step(MDROUT, 1'b0, o, e);
    checks++;
    if (o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mem_mdr got %h want %h", o, 32'hA5A5_A5A5); end
    load_r0(32'h1234_5678);
    go(GRB | ROUT | MDRIN);
    go(READ | WRITE);
    checks++;
    if (dut.mdatain !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mem_rw_old got %h want %h", dut.mdatain, 32'hA5A5_A5A5); end
    go(READ);
    checks++;
    if (dut.mdatain !== 32'h1234_5678) begin errors++; $display("FAIL mem_rw_new got %h want %h", dut.mdatain, 32'h1234_5678); end
  endtask

  task automatic test_mem_random;
    logic [31:0] o, e;
    logic [31:0] a [4];
    logic [31:0] v [4];
    for (int k = 0; k < 4; k++) begin
      a[k] = {$urandom_range(0, 255), 9'(k * 100 + $urandom_range(0, 99))};
      v[k] = $urandom;
      write_ram(a[k], v[k]);
    end
    for (int k = 3; k >= 0; k--) begin
      load_r0({23'($urandom), a[k][8:0]});
      go(GRB | ROUT | MARIN);
      go(MDRIN);
      go(READ);
      go(MDREAD | MDRIN);
      step(MDROUT, 1'b0, o, e);
      checks++;
      if (o !== v[k] || o !== e)
        begin errors++; $display("FAIL mem_rand_%0d got %h want %h", k, o, v[k]); end
    end
  endtask

  task automatic test_random_ops;
    logic [31:0] o, e;
    logic [21:0] m;
    load_r0($urandom);
    go(GRB | ROUT | IRIN);
    go(GRB | ROUT | YIN);
    for (int n = 0; n < 300; n++) begin
      m = '0;
      m[7:0]   = 8'($urandom & $urandom);
      m[13:8]  = 6'($urandom & $urandom & $urandom);
      m[15:14] = 2'($urandom);
      m[17:16] = 2'($urandom);
      m[21]    = ($urandom_range(0, 9) == 0);
      step(m, 1'b0, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL rand_bus_%0d ctl %h got %h want %h", n, m, o, e); end
      checks++;
      if ({PCq, IRq, MARq} !== {mpc, mir, mmar})
        begin errors++; $display("FAIL rand_regs_%0d got %h %h %h want %h %h %h", n, PCq, IRq, MARq, mpc, mir, mmar); end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] o, e;
    load_r0(32'h3);
    go(GRB | ROUT | PCIN);
    go(GRB | ROUT | MARIN);
    go(GRB | ROUT | YIN);
    step(GRB | ROUT | ZLOWIN | ZHIGHIN | PCIN, 1'b1, o, e);
    step(ZLOWOUT, 1'b0, o, e);
    checks++;
    if (o !== 32'h0) begin errors++; $display("FAIL midreset_zlow got %h want %h", o, 32'h0); end
    checks++;
    if (dut.zhigh_q !== 32'h0) begin errors++; $display("FAIL midreset_zhigh got %h want %h", dut.zhigh_q, 32'h0); end
    checks++;
    if ({PCq, MARq} !== 64'h0) begin errors++; $display("FAIL midreset_pc_mar got %h %h want 0 0", PCq, MARq); end
  endtask

  initial begin
    ctl   = '0;
    clear = 1'b1;
    @(posedge clock);
    #1;
    test_reset();
    test_fetch();
    test_andi();
    test_sign_ext();
    test_baout();
    test_add_carry();
    test_memory();
    test_mem_random();
    test_random_ops();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
